seq_mult_unit: RTL

//  Parametrised sequential shift-add multiplier: controller FSM plus datapath in one block.

---
 rtl/seq_mult_pkg.sv | 20 ++
 rtl/seq_mult_if.sv | 34 +++
 rtl/seq_mult_fsm.sv | 89 ++++++++
 rtl/seq_mult_unit.sv | 132 +++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// -----------------------------------------------------------------------------
// seq_mult_pkg
// Shared types and helpers for the sequential shift-add multiplier.
//   state_t   : controller state encoding {IDLE, CALC, DONE}, 2 bits
//   cnt_width : bit-counter width for a given operand width, never below 1
// -----------------------------------------------------------------------------
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // $clog2(1) is 0; clamp so the counter always has at least one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/seq_mult_if.sv
// -----------------------------------------------------------------------------
// seq_mult_if
// Handshake and data bundle between the operand source and seq_mult_unit.
//   start        : request, honoured only while the unit is idle
//   a, b         : multiplicand / multiplier (WIDTH bits)
//   signed_mode  : two's complement select (only with SEQ_MULT_SIGNED_EN)
//   busy         : unit is computing or presenting a result
//   done         : one-cycle result strobe
//   product      : 2*WIDTH-bit result, held until the next completion
// Modports: master = operand source / result consumer, slave = multiplier.
// Optional feature macro: SEQ_MULT_SIGNED_EN.
// -----------------------------------------------------------------------------
interface seq_mult_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
`ifdef SEQ_MULT_SIGNED_EN
    logic                   signed_mode;
`endif
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

`ifdef SEQ_MULT_SIGNED_EN
    modport master (output start, a, b, signed_mode, input busy, done, product);
    modport slave  (input start, a, b, signed_mode, output busy, done, product);
`else
    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
`endif

endinterface

// File: rtl/seq_mult_fsm.sv
// -----------------------------------------------------------------------------
// seq_mult_fsm
// Controller for the shift-add multiplier: state register, bit counter and
// the strobes the datapath needs.
//   clk, reset : clock (rising edge), asynchronous active-low reset
//   start      : operation request
//   busy       : high in CALC and DONE
//   done       : high for the single DONE cycle
//   accept     : start taken in IDLE this cycle (datapath loads operands)
//   step       : a CALC cycle (datapath processes one multiplier bit)
//   last       : final CALC cycle (cnt == WIDTH-1)
// -----------------------------------------------------------------------------
module seq_mult_fsm
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    output logic accept,
    output logic step,
    output logic last
);

    localparam int              CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter returns to 0 on the last step instead of incrementing past
    // WIDTH-1, so it never wraps inside an operation even when WIDTH is a
    // power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == LAST_CNT) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/seq_mult_unit.sv
// -----------------------------------------------------------------------------
// seq_mult_unit
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH in WIDTH compute
// cycles, one multiplier bit per cycle, start/busy/done handshake.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset (clears state and all registers)
//   bus   : seq_mult_if slave modport (start, a, b, [signed_mode],
//           busy, done, product)
// Optional feature macro: SEQ_MULT_SIGNED_EN adds two's complement operation
// selected per operation by signed_mode (sign-extended add, arithmetic shift,
// subtract on the final step). Without it the unit is unsigned only.
// The bus interface must be instantiated with the same WIDTH.
// -----------------------------------------------------------------------------
module seq_mult_unit
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    seq_mult_if.slave bus
);

    logic                 busy;
    logic                 done;
    logic                 accept;
    logic                 step;
    logic                 last;

    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     acc;
    logic [2*WIDTH-1:0]   product;

    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     acc_nxt;
    logic [WIDTH-1:0]     mplier_nxt;

`ifdef SEQ_MULT_SIGNED_EN
    logic                 signed_q;

    // One partial-product step at WIDTH+1 bits. In signed mode both terms
    // are sign-extended so the extra bit is the true sign, and the final
    // multiplier bit carries negative weight, hence the subtract.
    function automatic logic [WIDTH:0] step_sum(
        input logic [WIDTH-1:0] acc_v,
        input logic [WIDTH-1:0] mcand_v,
        input logic             add,
        input logic             sub,
        input logic             sgn
    );
        logic signed [WIDTH:0] acc_x;
        logic signed [WIDTH:0] mc_x;
        acc_x = $signed({sgn & acc_v[WIDTH-1], acc_v});
        mc_x  = $signed({sgn & mcand_v[WIDTH-1], mcand_v});
        if (!add) begin
            return acc_x;
        end
        if (sub) begin
            return acc_x - mc_x;
        end
        return acc_x + mc_x;
    endfunction
`else
    // One partial-product step; the extra bit holds the carry out.
    function automatic logic [WIDTH:0] step_sum(
        input logic [WIDTH-1:0] acc_v,
        input logic [WIDTH-1:0] mcand_v,
        input logic             add
    );
        return add ? ({1'b0, acc_v} + {1'b0, mcand_v}) : {1'b0, acc_v};
    endfunction
`endif

    seq_mult_fsm #(
        .WIDTH (WIDTH)
    ) u_fsm (
        .clk    (clk),
        .reset  (reset),
        .start  (bus.start),
        .busy   (busy),
        .done   (done),
        .accept (accept),
        .step   (step),
        .last   (last)
    );

    // Add stage, then {carry,acc,mplier} >> 1. Dropping sum[0] into the
    // multiplier's top bit is the shift; sum[WIDTH] is the carry (unsigned)
    // or the replicated sign (signed), which makes the shift arithmetic.
    always_comb begin
`ifdef SEQ_MULT_SIGNED_EN
        sum = step_sum(acc, mcand, mplier[0], last & signed_q, signed_q);
`else
        sum = step_sum(acc, mcand, mplier[0]);
`endif
        acc_nxt    = sum[WIDTH:1];
        mplier_nxt = {sum[0], mplier[WIDTH-1:1]};
    end

    // Register stage: operand capture on accept, one shift per CALC cycle,
    // product latched on the final step only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            product  <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            signed_q <= 1'b0;
`endif
        end else if (accept) begin
            mcand    <= bus.a;
            mplier   <= bus.b;
            acc      <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            signed_q <= bus.signed_mode;
`endif
        end else if (step) begin
            acc    <= acc_nxt;
            mplier <= mplier_nxt;
            if (last) begin
                product <= {acc_nxt, mplier_nxt};
            end
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = product;

endmodule
